// File: rtl/comm_slave.sv
// rtl/comm_slave.sv - UART 8N1 command endpoint: byte-pair receiver with timeout and one-byte response transmitter
module comm_slave #(
    parameter int BAUD_DIV = 2604,
    parameter int BYTE_TO  = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam int TW = $clog2(BYTE_TO + 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {WAIT_HIGH, WAIT_LOW} byte_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    logic            rx_meta_q, rx_sync_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_arm_q, rx_arm_d;
    logic            rx_done, rx_ferr, rx_exp;

    byte_state_t     by_state_q, by_state_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]      high_q, high_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            rdy_q, rdy_d;

    tx_state_t       tx_state_q, tx_state_d;
    logic [9:0]      tx_sh_q, tx_sh_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic            sent_q, sent_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= FULL;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_arm_q   <= 1'b0;
            by_state_q <= WAIT_HIGH;
            to_cnt_q   <= '0;
            high_q     <= '0;
            cmd_q      <= '0;
            rdy_q      <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '1;
            tx_cnt_q   <= FULL;
            tx_bit_q   <= '0;
            sent_q     <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_arm_q   <= rx_arm_d;
            by_state_q <= by_state_d;
            to_cnt_q   <= to_cnt_d;
            high_q     <= high_d;
            cmd_q      <= cmd_d;
            rdy_q      <= rdy_d;
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            sent_q     <= sent_d;
        end
    end

    // Receiver arms only after a full bit time of idle-high line, so it never
    // locks onto the middle of a frame after reset or a framing error.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_arm_d   = rx_arm_q;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        rx_exp     = (rx_cnt_q == CW'(1));
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_arm_q) begin
                    if (!rx_sync_q)  rx_cnt_d = FULL;
                    else if (rx_exp) rx_arm_d = 1'b1;
                    else             rx_cnt_d = rx_cnt_q - CW'(1);
                end else if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF;
                end
            end
            RX_START: begin
                if (!rx_exp) rx_cnt_d = rx_cnt_q - CW'(1);
                else if (rx_sync_q) rx_state_d = RX_IDLE;
                else begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = FULL;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (!rx_exp) rx_cnt_d = rx_cnt_q - CW'(1);
                else begin
                    rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                    rx_cnt_d = FULL;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            default: begin
                if (!rx_exp) rx_cnt_d = rx_cnt_q - CW'(1);
                else begin
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) rx_done = 1'b1;
                    else begin
                        rx_ferr  = 1'b1;
                        rx_arm_d = 1'b0;
                        rx_cnt_d = FULL;
                    end
                end
            end
        endcase
    end

    always_comb begin
        by_state_d = by_state_q;
        to_cnt_d   = to_cnt_q;
        high_d     = high_q;
        cmd_d      = cmd_q;
        rdy_d      = clr_cmd_rdy ? 1'b0 : rdy_q;
        case (by_state_q)
            WAIT_HIGH: begin
                if (rx_done) begin
                    high_d     = rx_sh_q;
                    to_cnt_d   = '0;
                    rdy_d      = 1'b0;
                    by_state_d = WAIT_LOW;
                end
            end
            default: begin
                if (rx_done) begin
                    cmd_d      = {high_q, rx_sh_q};
                    rdy_d      = 1'b1;
                    by_state_d = WAIT_HIGH;
                end else if (rx_ferr) begin
                    by_state_d = WAIT_HIGH;
                end else if (rx_state_q == RX_IDLE) begin
                    if (to_cnt_q == TW'(BYTE_TO - 1)) by_state_d = WAIT_HIGH;
                    else                              to_cnt_d = to_cnt_q + TW'(1);
                end
            end
        endcase
    end

    // Ones shift in behind the frame, so the line is idle-high once all ten bits are out.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        sent_d     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp && !sent_q) begin
                    tx_sh_d    = {1'b1, resp, 1'b0};
                    tx_cnt_d   = FULL;
                    tx_bit_d   = '0;
                    tx_state_d = TX_SHIFT;
                end
            end
            default: begin
                if (tx_cnt_q != CW'(1)) tx_cnt_d = tx_cnt_q - CW'(1);
                else begin
                    tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                    tx_cnt_d = FULL;
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                        sent_d     = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
        endcase
    end

    assign TX        = tx_sh_q[0];
    assign tx_busy   = (tx_state_q == TX_SHIFT);
    assign resp_sent = sent_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = rdy_q;
endmodule

// File: tb/tb_comm_slave.sv
// tb/tb_comm_slave.sv - scoreboard bench for comm_slave (BAUD_DIV=16, BYTE_TO=200)
module tb_comm_slave;
    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX, cmd_rdy, tx_busy, resp_sent;
    logic [15:0] cmd;

    int checks = 0;
    int failures = 0;
    logic [15:0] rxq[$];
    logic [7:0]  txq[$];
    logic        rdy_prev = 1'b0;

    comm_slave #(.BAUD_DIV(B), .BYTE_TO(200)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .tx_busy(tx_busy), .resp_sent(resp_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_rdy && !rdy_prev) begin
            if (rxq.size() == 0) check("cmd_extra", rxq.size(), 1);
            else                 check("cmd", cmd, rxq.pop_front());
        end
        rdy_prev = cmd_rdy;
    end

    // Drives the first nbits of an 8N1 frame; chk verifies cmd_rdy lands one cycle after the stop sample.
    task automatic frame(input logic [7:0] b, input logic stopv, input int nbits, input bit chk);
        logic [9:0] f;
        f = {stopv, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            RX = f[i];
            if (chk && i == 9) begin
                repeat (10) @(negedge clk);
                check("rdy_before", cmd_rdy, 0);
                @(negedge clk);
                check("rdy_at", cmd_rdy, 1);
                repeat (5) @(negedge clk);
            end else begin
                repeat (B) @(negedge clk);
            end
        end
        RX = 1'b1;
    endtask

    initial begin
        logic [9:0] txf;
        logic [7:0] dec;
        txf = {1'b1, 8'hA5, 1'b0};
        dec = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1);
        check("rst_cmd", cmd, 0);
        check("rst_rdy", cmd_rdy, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_sent", resp_sent, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        frame(8'hA5, 1'b1, 10, 1'b0);
        rxq.push_back(16'hA53C);
        frame(8'h3C, 1'b1, 10, 1'b1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("clr_rdy", cmd_rdy, 0);
        check("clr_cmd_hold", cmd, 16'hA53C);

        frame(8'h12, 1'b1, 10, 1'b0);
        repeat (300) @(negedge clk);
        frame(8'h34, 1'b1, 10, 1'b0);
        rxq.push_back(16'h3456);
        frame(8'h56, 1'b1, 10, 1'b0);
        repeat (20) @(negedge clk);

        frame(8'hFF, 1'b0, 10, 1'b0);
        repeat (40) @(negedge clk);
        frame(8'h01, 1'b1, 10, 1'b0);
        rxq.push_back(16'h0102);
        frame(8'h02, 1'b1, 10, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_cmd", cmd, 16'h0102);

        frame(8'h77, 1'b1, 10, 1'b0);
        repeat (20) @(negedge clk);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_cmd", cmd, 16'h0102);
        rxq.push_back(16'h7788);
        frame(8'h88, 1'b1, 10, 1'b0);
        repeat (20) @(negedge clk);

        resp = 8'hA5;
        send_resp = 1'b1;
        txq.push_back(8'hA5);
        for (int i = 1; i <= 170; i++) begin
            @(negedge clk);
            if (i == 1) send_resp = 1'b0;
            if (i == 49) begin
                send_resp = 1'b1;
                resp = 8'h00;
            end
            if (i == 50) begin
                send_resp = 1'b0;
                resp = 8'hA5;
            end
            if (i <= 160 && ((i - 1) % B == 0 || i % B == 0))
                check("tx_bit", TX, txf[(i - 1) / B]);
            if (i % B == 8 && i / B >= 1 && i / B <= 8) dec[i / B - 1] = TX;
            if (i == 160) begin
                check("busy_160", tx_busy, 1);
                check("sent_160", resp_sent, 0);
            end
            if (i == 161) begin
                check("sent_161", resp_sent, 1);
                check("busy_161", tx_busy, 0);
            end
            if (i == 162) check("sent_162", resp_sent, 0);
            if (i >= 161 && i % 3 == 0) check("tx_idle", TX, 1);
        end
        check("tx_byte", dec, txq.pop_front());

        frame(8'h11, 1'b1, 10, 1'b0);
        resp = 8'h5A;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        frame(8'h22, 1'b1, 5, 1'b0);
        rst_n = 1'b0;
        RX = 1'b1;
        @(negedge clk);
        check("mrst_tx", TX, 1);
        check("mrst_busy", tx_busy, 0);
        check("mrst_sent", resp_sent, 0);
        check("mrst_cmd", cmd, 0);
        check("mrst_rdy", cmd_rdy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        frame(8'hBE, 1'b1, 10, 1'b0);
        rxq.push_back(16'hBEEF);
        frame(8'hEF, 1'b1, 10, 1'b0);
        repeat (20) @(negedge clk);
        check("post_rst_cmd", cmd, 16'hBEEF);

        check("rxq_empty", rxq.size(), 0);
        check("txq_empty", txq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comm_slave.md
# comm_slave

Robot-side endpoint of the serial command link. It deserializes 8N1 UART frames arriving on RX and assembles each pair of bytes, high byte first, into a 16-bit command with a ready flag for the command processor. It also serializes a one-byte response back on TX. It is self-contained: bit-level receive and transmit logic, byte-pairing FSM and inter-byte timeout all live here.

## Interface
- BAUD_DIV, 2604: clk cycles per UART bit (50 MHz / 19200 baud); must be ≥ 8.
- BYTE_TO, 65536: max clk cycles from high-byte stop-bit sample to low-byte start-bit detect.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- RX  in  1  serial input, idle high, asynchronous to clk.
- TX  out  1  serial output, idle high; reset 1.
- cmd  out  16  last assembled command {high, low}; reset 16'h0000.
- cmd_rdy  out  1  a new command is valid; reset 0.
- clr_cmd_rdy  in  1  one-cycle acknowledge from the consumer.
- resp  in  8  response byte, sampled on an accepted send_resp.
- send_resp  in  1  request to transmit resp.
- tx_busy  out  1  transmitter active; reset 0.
- resp_sent  out  1  one-cycle pulse when the response stop bit completes; reset 0.

## Operation
- RX synchronizer: two flops, both reset to 1. All RX logic uses only the synchronized value.
- Bit receiver FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a sampled 0 enters START and loads the baud counter with BAUD_DIV/2.
  - START: at counter expiry, re-sample. If the value is 1 (glitch), return to IDLE. If 0, go to DATA with a full BAUD_DIV count.
  - DATA: shift in 8 bits LSB-first, one sample per BAUD_DIV expiry.
  - STOP: sample once. A 1 delivers the byte. A 0 is a framing error: discard the byte and return to IDLE.
  - IDLE after a framing error also requires RX to be high before it arms again.
- Byte FSM: WAIT_HIGH, WAIT_LOW.
  - WAIT_HIGH: a delivered byte goes into a high_byte register; go to WAIT_LOW and clear the timeout counter.
  - WAIT_LOW: the timeout counter increments while the receiver is in IDLE.
    - Counter reaching BYTE_TO: discard high_byte and return to WAIT_HIGH.
    - Delivered byte: cmd ← {high_byte, byte}, set cmd_rdy, return to WAIT_HIGH.
  - Framing error in WAIT_LOW: discard the pair and return to WAIT_HIGH.
- cmd_rdy set/clear:
  - Cleared by clr_cmd_rdy.
  - Also cleared when a high byte is delivered; a stale command is not held across a new pair.
  - Set and clear in the same cycle: set wins.
- cmd holds its value until the next complete pair. A discarded or incomplete pair never alters cmd.
- Transmitter FSM: TX_IDLE, TX_SHIFT.
  - TX_IDLE: send_resp loads a 10-bit shift register {1, resp, 0}, asserts tx_busy and enters TX_SHIFT.
  - TX_SHIFT: TX is the shift register LSB. Shift every BAUD_DIV cycles for 10 bit periods.
  - After the 10th bit period: pulse resp_sent, drop tx_busy, return to TX_IDLE.
  - send_resp while tx_busy is ignored; it is not queued.
- Receive and transmit paths are fully independent; full duplex is allowed.

## Timing
- TX falls on the cycle after send_resp is accepted. Each bit lasts exactly BAUD_DIV cycles.
- resp_sent and the tx_busy fall occur in the same cycle, 10·BAUD_DIV + 1 cycles after send_resp.
- TX is back in the idle-high state from that cycle on.
- A new send_resp is accepted in the cycle after resp_sent.
- The RX start edge is seen 2 cycles after the pin falls (synchronizer).
- The stop bit is sampled 9.5·BAUD_DIV cycles after the start edge is seen, ±1 cycle.
- cmd and cmd_rdy update in the cycle after the low-byte stop sample.
- Reset mid-frame, either direction:
  - All FSMs return to idle; TX=1; cmd_rdy=0; cmd=0; high_byte discarded.
  - After reset release, the receiver waits for a fresh falling edge and does not resync into the middle of a frame.

## Test plan
- BAUD_DIV=16. Send frames 8'hA5 then 8'h3C back-to-back → cmd=16'hA53C and cmd_rdy=1 one cycle after the second stop sample. Pulse clr_cmd_rdy → cmd_rdy=0 on the next cycle; cmd stays 16'hA53C.
- Send 8'h12, idle past BYTE_TO (set to 200), send 8'h34, 8'h56 → cmd=16'h3456 and 8'h12 never appears; one cmd_rdy assertion in total.
- Send 8'hFF with stop bit forced 0, then 8'h01, 8'h02 → framing error discarded; cmd=16'h0102.
- Drive a 4-cycle low glitch on RX → no byte delivered; FSM state and cmd unchanged.
- send_resp with resp=8'hA5 → TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; resp_sent at cycle 161. A second send_resp at cycle 50 is ignored.
- Assert rst_n low mid-way through a received low byte and mid-way through a transmitted response → outputs at reset values. A subsequent clean pair 16'hBEEF is received correctly.
